// File: rtl/co2_lcd_formatter.sv
// Turns a 16-bit CO2 ppm reading into a 14-byte LCD line ("CO2:  415 ppm") streamed over valid/ready.
// Binary-to-BCD runs one bit per clock using shift-add-3, so the datapath holds no divider.
module co2_lcd_formatter #(
    parameter logic [6:0]  LINE_ADDR = 7'h00,
    parameter logic [15:0] MAX_PPM   = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        char_rs,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd13;

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        over_q, over_d;
    logic        sample_ready_q, sample_ready_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  char_data_q, char_data_d;
    logic        char_rs_q, char_rs_d;
    logic        frame_done_q, frame_done_d;

    logic [19:0] bcd_adj;
    logic [4:0]  digit_nz;
    logic        unused_bcd_msb;

    // digit_nz[k] is set when digit k or any higher digit is non-zero (drives leading-zero blanking)
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = bcd_q[4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
            assign digit_nz[gi] = |bcd_q[19:4*gi];
        end
    endgenerate

    // The top digit never exceeds 6, so the adjusted MSB shifted out is always zero.
    assign unused_bcd_msb = bcd_adj[19];

    logic [3:0] sel_idx;
    logic [2:0] dsel;
    logic [3:0] sel_digit;
    logic [7:0] digit_byte;
    logic [7:0] sel_byte;
    logic       sel_rs;

    // Once a byte is on the bus, the next one to load is idx+1; before that it is idx itself.
    always_comb begin
        sel_idx = char_valid_q ? (idx_q + 4'd1) : idx_q;
        dsel    = 3'd0;
        if (sel_idx >= 4'd5 && sel_idx <= 4'd9) begin
            dsel = 3'(4'd9 - sel_idx);
        end
        sel_digit = bcd_q[{dsel, 2'b00} +: 4];
        if (over_q) begin
            digit_byte = 8'h2D;
        end else if (!digit_nz[dsel] && dsel != 3'd0) begin
            digit_byte = 8'h20;
        end else begin
            digit_byte = 8'h30 + {4'h0, sel_digit};
        end

        sel_rs = 1'b1;
        case (sel_idx)
            4'd0: begin
                sel_byte = 8'h80 | {1'b0, LINE_ADDR};
                sel_rs   = 1'b0;
            end
            4'd1:    sel_byte = 8'h43;
            4'd2:    sel_byte = 8'h4F;
            4'd3:    sel_byte = 8'h32;
            4'd4:    sel_byte = 8'h3A;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: sel_byte = digit_byte;
            4'd10:   sel_byte = 8'h20;
            4'd11:   sel_byte = 8'h70;
            4'd12:   sel_byte = 8'h70;
            default: sel_byte = 8'h6D;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bin_d          = bin_q;
        bcd_d          = bcd_q;
        bit_cnt_d      = bit_cnt_q;
        idx_d          = idx_q;
        over_d         = over_q;
        sample_ready_d = sample_ready_q;
        char_valid_d   = char_valid_q;
        char_data_d    = char_data_q;
        char_rs_d      = char_rs_q;
        frame_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                sample_ready_d = 1'b1;
                if (sample_valid) begin
                    bin_d          = sample_data;
                    over_d         = (sample_data > MAX_PPM);
                    bcd_d          = 20'd0;
                    bit_cnt_d      = 5'd16;
                    sample_ready_d = 1'b0;
                    state_d        = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d     = {bcd_adj[18:0], bin_q[15]};
                bin_d     = {bin_q[14:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 5'd1;
                if (bit_cnt_q == 5'd1) begin
                    idx_d   = 4'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!char_valid_q) begin
                    char_valid_d = 1'b1;
                    char_data_d  = sel_byte;
                    char_rs_d    = sel_rs;
                end else if (char_ready) begin
                    if (idx_q == LAST_IDX) begin
                        char_valid_d   = 1'b0;
                        frame_done_d   = 1'b1;
                        sample_ready_d = 1'b1;
                        idx_d          = 4'd0;
                        state_d        = S_IDLE;
                    end else begin
                        idx_d       = idx_q + 4'd1;
                        char_data_d = sel_byte;
                        char_rs_d   = sel_rs;
                    end
                end
            end
            default: begin
                sample_ready_d = 1'b1;
                char_valid_d   = 1'b0;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            bin_q          <= 16'd0;
            bcd_q          <= 20'd0;
            bit_cnt_q      <= 5'd0;
            idx_q          <= 4'd0;
            over_q         <= 1'b0;
            sample_ready_q <= 1'b1;
            char_valid_q   <= 1'b0;
            char_data_q    <= 8'h00;
            char_rs_q      <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bin_q          <= bin_d;
            bcd_q          <= bcd_d;
            bit_cnt_q      <= bit_cnt_d;
            idx_q          <= idx_d;
            over_q         <= over_d;
            sample_ready_q <= sample_ready_d;
            char_valid_q   <= char_valid_d;
            char_data_q    <= char_data_d;
            char_rs_q      <= char_rs_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign sample_ready = sample_ready_q;
    assign char_valid   = char_valid_q;
    assign char_data    = char_data_q;
    assign char_rs      = char_rs_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_co2_lcd_formatter.sv
// Scoreboard bench: stimulus pushes expected {last, rs, byte} entries; a negedge monitor checks every presented byte.
// dut1 runs with LINE_ADDR=7'h40 / MAX_PPM=16'hFFFF; sel chooses which instance the monitor watches.
module tb_co2_lcd_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sv0 = 1'b0, sv1 = 1'b0, rdy = 1'b0;
    logic [15:0] sdata = 16'd0;
    logic        sr0, cv0, rs0, fd0, sr1, cv1, rs1, fd1;
    logic [7:0]  cd0, cd1;

    always #5 clk = ~clk;

    co2_lcd_formatter dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv0), .sample_data(sdata), .sample_ready(sr0),
        .char_valid(cv0), .char_ready(rdy), .char_data(cd0), .char_rs(rs0), .frame_done(fd0)
    );

    co2_lcd_formatter #(.LINE_ADDR(7'h40), .MAX_PPM(16'hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv1), .sample_data(sdata), .sample_ready(sr1),
        .char_valid(cv1), .char_ready(rdy), .char_data(cd1), .char_rs(rs1), .frame_done(fd1)
    );

    int         checks = 0, failures = 0;
    int         cyc = 0, nbytes = 0, frames_done = 0, done_cyc = 0, t0 = 0;
    bit         sel = 1'b0;
    bit         exp_done = 1'b0;
    logic [9:0] exp_q[$];
    logic [7:0] f415 [14] = '{8'h80, 8'h43, 8'h4F, 8'h32, 8'h3A, 8'h20, 8'h20,
                              8'h34, 8'h31, 8'h35, 8'h20, 8'h70, 8'h70, 8'h6D};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        logic       m_v, m_rs, m_fd, o_v;
        logic [7:0] m_d;
        logic [9:0] e;
        m_v  = sel ? cv1 : cv0;
        m_rs = sel ? rs1 : rs0;
        m_d  = sel ? cd1 : cd0;
        m_fd = sel ? fd1 : fd0;
        o_v  = sel ? cv0 : cv1;
        if (rst_n) begin
            if (m_fd || exp_done) chk("frame_done", 32'(m_fd), 32'(exp_done));
            if (m_fd) begin
                frames_done++;
                done_cyc = cyc;
            end
            exp_done = 1'b0;
            if (o_v) chk("idle_instance_valid", 32'(o_v), 32'd0);
            if (m_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got rs=%0b data=%02h expected no byte", m_rs, m_d);
                end else begin
                    chk($sformatf("byte_idx%0d", nbytes), 32'({m_rs, m_d}), 32'(exp_q[0][8:0]));
                    if (rdy) begin
                        e = exp_q.pop_front();
                        $display("byte idx=%0d rs=%0b data=%02h", nbytes, m_rs, m_d);
                        nbytes++;
                        if (e[9]) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_entry(input int i, input logic [7:0] b);
        exp_q.push_back({(i == 13), (i != 0), b});
    endtask

    task automatic push_table();
        nbytes = 0;
        for (int i = 0; i < 14; i++) push_entry(i, f415[i]);
    endtask

    task automatic push_model(input logic [15:0] v, input logic [15:0] maxp, input logic [6:0] addr);
        int         x;
        logic [3:0] d [5];
        bit         seen;
        logic [7:0] b;
        nbytes = 0;
        x = int'(v);
        for (int k = 0; k < 5; k++) begin
            d[k] = 4'(x % 10);
            x = x / 10;
        end
        push_entry(0, {1'b1, addr});
        push_entry(1, 8'h43);
        push_entry(2, 8'h4F);
        push_entry(3, 8'h32);
        push_entry(4, 8'h3A);
        seen = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            if (v > maxp) b = 8'h2D;
            else if (d[k] == 4'd0 && !seen && k != 0) b = 8'h20;
            else begin
                seen = 1'b1;
                b = 8'h30 + {4'h0, d[k]};
            end
            push_entry(9 - k, b);
        end
        push_entry(10, 8'h20);
        push_entry(11, 8'h70);
        push_entry(12, 8'h70);
        push_entry(13, 8'h6D);
    endtask

    task automatic send(input bit which, input logic [15:0] v);
        int n = 0;
        @(posedge clk); #1;
        while (!(which ? sr1 : sr0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sample_ready_before_send", 32'(which ? sr1 : sr0), 32'd1);
        sdata = v;
        if (which) sv1 = 1'b1; else sv0 = 1'b1;
        t0 = cyc;
        $display("sample dut%0d value=%0d", which, v);
        @(posedge clk); #1;
        sv0 = 1'b0;
        sv1 = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int prev = frames_done;
        int n = 0;
        while (frames_done == prev && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_frame_done_seen"}, 32'(frames_done - prev), 32'd1);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  held;
        int  prev;

        // Reset values
        #23;
        chk("rst_sample_ready", 32'(sr0), 32'd1);
        chk("rst_char_valid", 32'(cv0), 32'd0);
        chk("rst_char_data", 32'(cd0), 32'h00);
        chk("rst_char_rs", 32'(rs0), 32'd0);
        chk("rst_frame_done", 32'(fd0), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        rdy = 1'b1;

        // 1: 415 with ready held high, latency to frame_done
        sel = 1'b0;
        push_table();
        send(1'b0, 16'd415);
        wait_frame("s1");
        chk("s1_latency", 32'(done_cyc - t0), 32'd32);

        // 2: zero, exact limit, one above limit
        push_model(16'd0, 16'd5000, 7'h00);
        send(1'b0, 16'd0);
        wait_frame("s2_zero");
        push_model(16'd5000, 16'd5000, 7'h00);
        send(1'b0, 16'd5000);
        wait_frame("s2_5000");
        push_model(16'd5001, 16'd5000, 7'h00);
        send(1'b0, 16'd5001);
        wait_frame("s2_5001");

        // 3: alternate parameters, full-scale reading
        sel = 1'b1;
        push_model(16'd65535, 16'hFFFF, 7'h40);
        send(1'b1, 16'd65535);
        wait_frame("s3");
        sel = 1'b0;

        // 4: random backpressure with a 10-cycle stall at index 7
        push_table();
        rdy = 1'b0;
        send(1'b0, 16'd415);
        held = 1'b0;
        n = 0;
        prev = frames_done;
        while (frames_done == prev && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (!held && nbytes == 7 && cv0) begin
                rdy = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                held = 1'b1;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
        end
        chk("s4_stall_reached", 32'(held), 32'd1);
        chk("s4_frame_done_seen", 32'(frames_done - prev), 32'd1);
        chk("s4_queue_drained", 32'(exp_q.size()), 32'd0);
        rdy = 1'b1;

        // 5: samples while busy ignored; sample in frame_done cycle accepted
        push_model(16'd777, 16'd5000, 7'h00);
        send(1'b0, 16'd777);
        @(posedge clk); #1;
        chk("s5_ready_convert", 32'(sr0), 32'd0);
        sdata = 16'd999;
        sv0 = 1'b1;
        @(posedge clk); #1;
        sv0 = 1'b0;
        n = 0;
        while (nbytes < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s5_ready_emit", 32'(sr0), 32'd0);
        sv0 = 1'b1;
        @(posedge clk); #1;
        sv0 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!fd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s5_done_pulse", 32'(fd0), 32'd1);
        chk("s5_ready_in_done_cycle", 32'(sr0), 32'd1);
        push_model(16'd42, 16'd5000, 7'h00);
        sdata = 16'd42;
        sv0 = 1'b1;
        $display("sample dut0 value=42 (frame_done cycle)");
        @(posedge clk); #1;
        sv0 = 1'b0;
        wait_frame("s5_next");

        // 6: reset mid-frame, then a clean frame
        push_model(16'd888, 16'd5000, 7'h00);
        send(1'b0, 16'd888);
        n = 0;
        while (!(nbytes == 6 && cv0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s6_reached_idx6", 32'(nbytes), 32'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_char_valid", 32'(cv0), 32'd0);
        chk("s6_rst_char_data", 32'(cd0), 32'h00);
        chk("s6_rst_sample_ready", 32'(sr0), 32'd1);
        chk("s6_rst_frame_done", 32'(fd0), 32'd0);
        exp_q.delete();
        exp_done = 1'b0;
        prev = frames_done;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("s6_no_frame_done", 32'(frames_done - prev), 32'd0);
        push_model(16'd123, 16'd5000, 7'h00);
        send(1'b0, 16'd123);
        wait_frame("s6_after");

        repeat (5) @(posedge clk);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
